// File: rtl/gpu_pkg.sv
// Types and default widths shared by the core pipeline blocks: the core and fetcher
// state encodings and the default program memory geometry.
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

    // Plain vector with named constants so older tools and netlists see a fixed encoding.
    typedef logic [1:0] fetcher_state_t;
    localparam fetcher_state_t F_IDLE     = 2'd0;
    localparam fetcher_state_t F_FETCHING = 2'd1;
    localparam fetcher_state_t F_FETCHED  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Per-core fetch stage: owns the PC, fetches instructions over a valid/ready handshake
// and skips the memory round-trip when the PC matches the last fetched address.
module instr_fetch_unit
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter bit ENABLE_REUSE          = 1'b1,
    parameter int PERF_CNT_BITS         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             block_start,
    input  core_state_t                      core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    input  logic                             load_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output fetcher_state_t                   fetcher_state,
    output logic [PERF_CNT_BITS-1:0]         fetch_req_count
);

    localparam int AW = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = PROGRAM_MEM_DATA_BITS;

    fetcher_state_t state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic           valid_q, valid_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  instr_q, instr_d;
    logic [AW-1:0]  tag_q, tag_d;
    logic           tag_valid_q, tag_valid_d;
    logic           reuse_hit;
    logic           issue_req;

    assign reuse_hit = ENABLE_REUSE && tag_valid_q && (tag_q == pc_q);

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        issue_req   = 1'b0;

        case (state_q)
            F_IDLE: begin
                if (core_state == FETCH) begin
                    if (reuse_hit) begin
                        state_d = F_FETCHED;
                    end else begin
                        state_d   = F_FETCHING;
                        valid_d   = 1'b1;
                        addr_d    = pc_q;
                        issue_req = 1'b1;
                    end
                end
            end
            F_FETCHING: begin
                // Once issued, the request is held until memory answers, whatever the core does.
                if (mem_read_ready) begin
                    state_d     = F_FETCHED;
                    valid_d     = 1'b0;
                    instr_d     = mem_read_data;
                    tag_d       = addr_q;
                    tag_valid_d = 1'b1;
                end
            end
            F_FETCHED: begin
                if (core_state == DECODE) begin
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // block_start wins over a same-cycle UPDATE; address wrap is plain modulo arithmetic.
    always_comb begin
        pc_d = pc_q;
        if (block_start) begin
            pc_d = '0;
        end else if (core_state == UPDATE) begin
            pc_d = load_pc ? next_pc : pc_q + AW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= F_IDLE;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // NOTE: the tag is pure data qualified by tag_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    sat_counter #(
        .WIDTH(PERF_CNT_BITS)
    ) u_req_counter (
        .clk    (clk),
        .clear_i(reset),
        .inc_i  (issue_req),
        .count_o(fetch_req_count)
    );

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign pc               = pc_q;
    assign instruction      = instr_q;
    assign fetcher_state    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: instance 0 has reuse enabled and a 16-bit counter,
// instance 1 has reuse disabled and a 2-bit counter. A program-level model predicts outputs.
module tb_instr_fetch_unit;
    import gpu_pkg::*;

    logic           clk;
    logic           rst     [2];
    logic           bstart  [2];
    core_state_t    cs      [2];
    logic [7:0]     npc     [2];
    logic           lpc     [2];
    logic           rdy     [2];
    logic [15:0]    rdata   [2];
    logic           vld     [2];
    logic [7:0]     addr    [2];
    logic [7:0]     pc_o    [2];
    logic [15:0]    instr_o [2];
    fetcher_state_t fst     [2];
    logic [15:0]    cnt_a;
    logic [1:0]     cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the program counter, reuse buffer and counter should hold.
    int m_pc        [2];
    int m_tag       [2];
    bit m_tag_valid [2];
    int m_instr     [2];
    int m_count     [2];
    bit m_reuse     [2] = '{1'b1, 1'b0};
    int m_cnt_max   [2] = '{65535, 3};

    instr_fetch_unit #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .ENABLE_REUSE(1'b1),
        .PERF_CNT_BITS(16)
    ) dut_a (
        .clk(clk), .reset(rst[0]), .block_start(bstart[0]), .core_state(cs[0]),
        .next_pc(npc[0]), .load_pc(lpc[0]), .mem_read_valid(vld[0]),
        .mem_read_address(addr[0]), .mem_read_ready(rdy[0]), .mem_read_data(rdata[0]),
        .pc(pc_o[0]), .instruction(instr_o[0]), .fetcher_state(fst[0]),
        .fetch_req_count(cnt_a)
    );

    instr_fetch_unit #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .ENABLE_REUSE(1'b0),
        .PERF_CNT_BITS(2)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .block_start(bstart[1]), .core_state(cs[1]),
        .next_pc(npc[1]), .load_pc(lpc[1]), .mem_read_valid(vld[1]),
        .mem_read_address(addr[1]), .mem_read_ready(rdy[1]), .mem_read_data(rdata[1]),
        .pc(pc_o[1]), .instruction(instr_o[1]), .fetcher_state(fst[1]),
        .fetch_req_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int get_cnt(input int i);
        return (i == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1; cs[i] = IDLE; rdy[i] = 1'b0; bstart[i] = 1'b0; lpc[i] = 1'b0;
        step();
        rst[i] = 1'b0;
        m_pc[i] = 0; m_tag_valid[i] = 1'b0; m_instr[i] = 0; m_count[i] = 0;
    endtask

    task automatic do_block_start(input int i);
        bstart[i] = 1'b1;
        step();
        bstart[i] = 1'b0;
        m_pc[i] = 0;
        n_checks++;
        if (pc_o[i] !== 8'h00) begin
            n_fail++; $display("FAIL block_start[%0d] pc: got %h want 00", i, pc_o[i]);
        end
    endtask

    task automatic do_update(input int i, input bit load, input int nxt, input string name);
        cs[i] = UPDATE; lpc[i] = load; npc[i] = 8'(nxt);
        step();
        cs[i] = IDLE; lpc[i] = 1'b0;
        m_pc[i] = load ? nxt : (m_pc[i] + 1) % 256;
        n_checks++;
        if (pc_o[i] !== 8'(m_pc[i])) begin
            n_fail++; $display("FAIL %s pc: got %h want %h", name, pc_o[i], 8'(m_pc[i]));
        end
    endtask

    // Runs FETCH until F_FETCHED (memory answers after wait_cycles valid cycles), then DECODE.
    task automatic do_fetch(input int i, input int wait_cycles, input logic [15:0] data,
                            input string name);
        bit hit;
        hit = m_reuse[i] && m_tag_valid[i] && (m_tag[i] == m_pc[i]);
        cs[i] = FETCH;
        step();
        if (hit) begin
            n_checks++;
            if (fst[i] !== F_FETCHED || vld[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s reuse: state=%0d valid=%0b want state=%0d valid=0",
                         name, fst[i], vld[i], F_FETCHED);
            end
            n_checks++;
            if (instr_o[i] !== 16'(m_instr[i])) begin
                n_fail++; $display("FAIL %s reuse instr: got %h want %h",
                                   name, instr_o[i], 16'(m_instr[i]));
            end
            n_checks++;
            if (get_cnt(i) != m_count[i]) begin
                n_fail++; $display("FAIL %s reuse count: got %0d want %0d",
                                   name, get_cnt(i), m_count[i]);
            end
        end else begin
            if (m_count[i] < m_cnt_max[i]) m_count[i]++;
            for (int k = 1; k <= wait_cycles; k++) begin
                n_checks++;
                if (vld[i] !== 1'b1 || addr[i] !== 8'(m_pc[i]) || fst[i] !== F_FETCHING) begin
                    n_fail++;
                    $display("FAIL %s req cycle %0d: valid=%0b addr=%h state=%0d want 1/%h/%0d",
                             name, k, vld[i], addr[i], fst[i], 8'(m_pc[i]), F_FETCHING);
                end
                if (k == 1) begin
                    n_checks++;
                    if (get_cnt(i) != m_count[i]) begin
                        n_fail++; $display("FAIL %s count: got %0d want %0d",
                                           name, get_cnt(i), m_count[i]);
                    end
                end
                if (k == wait_cycles) begin
                    rdy[i] = 1'b1; rdata[i] = data;
                end else begin
                    rdata[i] = 16'($urandom);
                end
                step();
            end
            rdy[i] = 1'b0; rdata[i] = ~data;
            m_instr[i] = int'(data); m_tag[i] = m_pc[i]; m_tag_valid[i] = 1'b1;
            n_checks++;
            if (fst[i] !== F_FETCHED || vld[i] !== 1'b0 || instr_o[i] !== data) begin
                n_fail++;
                $display("FAIL %s done: state=%0d valid=%0b instr=%h want %0d/0/%h",
                         name, fst[i], vld[i], instr_o[i], F_FETCHED, data);
            end
        end
        cs[i] = DECODE;
        step();
        cs[i] = IDLE;
        n_checks++;
        if (fst[i] !== F_IDLE || instr_o[i] !== 16'(m_instr[i])) begin
            n_fail++; $display("FAIL %s decode: state=%0d instr=%h want %0d/%h",
                               name, fst[i], instr_o[i], F_IDLE, 16'(m_instr[i]));
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        n_checks++;
        if (pc_o[0] !== 8'h00 || fst[0] !== F_IDLE || vld[0] !== 1'b0 || addr[0] !== 8'h00 ||
            instr_o[0] !== 16'h0000 || cnt_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: pc=%h state=%0d valid=%0b addr=%h instr=%h count=%0d want all zero",
                     pc_o[0], fst[0], vld[0], addr[0], instr_o[0], cnt_a);
        end
    endtask

    task automatic test_first_fetch();
        do_block_start(0);
        do_fetch(0, 3, 16'hA1B2, "first_fetch");
        n_checks++;
        if (instr_o[0] !== 16'hA1B2 || cnt_a !== 16'd1) begin
            n_fail++; $display("FAIL first_fetch final: instr=%h count=%0d want a1b2/1",
                               instr_o[0], cnt_a);
        end
    endtask

    task automatic test_sequential();
        do_update(0, 1'b1, 8'h05, "branch_05");
        do_update(0, 1'b0, 0, "seq_05_06");
        do_fetch(0, 1, 16'h0606, "fetch_06");
        do_update(0, 1'b1, 8'hFF, "branch_ff");
        do_update(0, 1'b0, 0, "wrap_ff");
        n_checks++;
        if (pc_o[0] !== 8'h00) begin
            n_fail++; $display("FAIL wrap explicit: pc got %h want 00", pc_o[0]);
        end
    endtask

    task automatic test_branch();
        do_update(0, 1'b1, 8'h20, "branch_20");
        do_fetch(0, 2, 16'h2020, "fetch_20");
    endtask

    task automatic test_reuse();
        int saved;
        do_update(0, 1'b1, 8'h10, "branch_10");
        do_fetch(0, 2, 16'h1010, "reuse_first");
        saved = int'(cnt_a);
        do_update(0, 1'b1, 8'h10, "self_loop_10");
        do_fetch(0, 2, 16'hDEAD, "reuse_second");
        n_checks++;
        if (int'(cnt_a) != saved || instr_o[0] !== 16'h1010) begin
            n_fail++; $display("FAIL reuse explicit: count=%0d instr=%h want %0d/1010",
                               cnt_a, instr_o[0], saved);
        end
    endtask

    task automatic test_block_start_priority();
        do_update(0, 1'b1, 8'h00, "branch_00");
        do_fetch(0, 1, 16'h0B0B, "fetch_00");
        do_update(0, 1'b0, 0, "seq_00_01");
        bstart[0] = 1'b1; cs[0] = UPDATE; lpc[0] = 1'b1; npc[0] = 8'h44;
        step();
        bstart[0] = 1'b0; cs[0] = IDLE; lpc[0] = 1'b0;
        m_pc[0] = 0;
        n_checks++;
        if (pc_o[0] !== 8'h00) begin
            n_fail++; $display("FAIL block_start_vs_update pc: got %h want 00", pc_o[0]);
        end
        do_fetch(0, 1, 16'hBAD0, "after_block_start");
    endtask

    task automatic test_spurious_ready();
        rdy[0] = 1'b1; rdata[0] = 16'($urandom);
        step();
        rdy[0] = 1'b0;
        n_checks++;
        if (fst[0] !== F_IDLE || vld[0] !== 1'b0 || instr_o[0] !== 16'(m_instr[0])) begin
            n_fail++; $display("FAIL spurious_ready: state=%0d valid=%0b instr=%h want %0d/0/%h",
                               fst[0], vld[0], instr_o[0], F_IDLE, 16'(m_instr[0]));
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_update(0, 1'b1, 8'h77, "branch_77");
        cs[0] = FETCH;
        step();
        step();
        n_checks++;
        if (vld[0] !== 1'b1) begin
            n_fail++; $display("FAIL mid_fetch pre-reset valid: got %0b want 1", vld[0]);
        end
        rst[0] = 1'b1; cs[0] = IDLE;
        step();
        rst[0] = 1'b0; rdy[0] = 1'b1; rdata[0] = 16'h5555;
        step();
        rdy[0] = 1'b0;
        m_pc[0] = 0; m_tag_valid[0] = 1'b0; m_instr[0] = 0; m_count[0] = 0;
        n_checks++;
        if (pc_o[0] !== 8'h00 || fst[0] !== F_IDLE || vld[0] !== 1'b0 || addr[0] !== 8'h00 ||
            instr_o[0] !== 16'h0000 || cnt_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_fetch reset: pc=%h state=%0d valid=%0b addr=%h instr=%h count=%0d want all zero",
                     pc_o[0], fst[0], vld[0], addr[0], instr_o[0], cnt_a);
        end
        do_fetch(0, 2, 16'h1357, "post_reset_fetch");
    endtask

    task automatic test_random();
        bit load;
        int nxt;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) do_block_start(0);
            do_fetch(0, int'($urandom_range(1, 4)), 16'($urandom), "rand_fetch");
            load = 1'($urandom_range(0, 1));
            nxt  = ($urandom_range(0, 1) == 1) ? m_pc[0] : int'($urandom_range(0, 255));
            do_update(0, load, nxt, "rand_update");
        end
    endtask

    task automatic test_no_reuse_saturation();
        do_reset(1);
        do_block_start(1);
        for (int n = 0; n < 5; n++) begin
            do_fetch(1, 1 + (n % 2), 16'(16'hC000 + n), "noreuse_sat");
            do_update(1, 1'b1, 0, "noreuse_loop");
        end
        n_checks++;
        if (cnt_b !== 2'd3) begin
            n_fail++; $display("FAIL saturation: count got %0d want 3", cnt_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; bstart[i] = 1'b0; cs[i] = IDLE; npc[i] = 8'h00;
            lpc[i] = 1'b0; rdy[i] = 1'b0; rdata[i] = 16'h0000;
        end
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_reuse();
        test_block_start_priority();
        test_spurious_ready();
        test_reset_mid_fetch();
        test_random();
        test_no_reuse_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
